mult_share_arbiter: RTL and testbench

Shares one 4x4 combinational multiplier (comb_multiplier) among NREQ requesters. Arbitration is round-robin. Accepted operands are registered and fed to the multiplier. The product is registered and presented on a valid/ready result port tagged with the requester ID. A saturating completed-operation counter is included for lab bring-up and debug.

---
 rtl/mult_share_arbiter.sv | 87 ++++++++
 tb/tb_mult_share_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one 4x4 multiplier among NREQ requesters
module comb_multiplier (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    assign p = a * b;
endmodule

module mult_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] a_in,
    input  logic [4*NREQ-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic              res_valid,
    output logic [IDW-1:0]    res_id,
    output logic [7:0]        res_product,
    input  logic              res_ready,
    output logic              busy,
    output logic [CNTW-1:0]   ops_count
);
    typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_t;
    state_t state;
    logic [IDW-1:0] ptr, id, off, gsel;
    logic [IDW:0] sum;
    logic [NREQ-1:0] rr;
    logic [3:0] op_a, op_b;
    logic [7:0] prod;
    logic found;

    comb_multiplier u_mul (.a(op_a), .b(op_b), .p(prod));

    // rotate requests so bit 0 is the pointer position, then take the lowest set bit
    assign rr = NREQ'({req, req} >> ptr);
    assign found = |req;
    always_comb begin
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rr[k]) off = k[IDW-1:0];
    end
    assign sum  = {1'b0, ptr} + {1'b0, off};
    assign gsel = IDW'(sum >= (IDW+1)'(NREQ) ? sum - (IDW+1)'(NREQ) : sum);
    assign gnt  = (state == IDLE && !rst && found) ? NREQ'(1'b1) << gsel : '0;
    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            id          <= '0;
            op_a        <= '0;
            op_b        <= '0;
            res_valid   <= 1'b0;
            res_id      <= '0;
            res_product <= '0;
            ops_count   <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    op_a  <= a_in[4*gsel +: 4];
                    op_b  <= b_in[4*gsel +: 4];
                    id    <= gsel;
                    ptr   <= (gsel == IDW'(NREQ - 1)) ? '0 : gsel + 1'b1;
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    res_product <= prod;
                    res_id      <= id;
                    res_valid   <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: if (res_ready) begin
                    res_valid <= 1'b0;
                    if (~&ops_count) ops_count <= ops_count + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed scoreboard bench for mult_share_arbiter
module tb_mult_share_arbiter;
    logic clk = 0, rst = 1, res_ready = 0;
    logic [3:0] req = 4'hf, gnt;
    logic [15:0] a_in = 0, b_in = 0;
    logic res_valid, busy;
    logic [1:0] res_id;
    logic [7:0] res_product;
    logic [15:0] ops_count;
    int errors = 0, checks = 0, cyc = 0, c, prev;
    logic [9:0] rq[$], e;
    logic [3:0] gq[$];
    logic hs;

    mult_share_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
        .res_valid(res_valid), .res_id(res_id), .res_product(res_product),
        .res_ready(res_ready), .busy(busy), .ops_count(ops_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: grants and result handshakes are checked against the expected queues
    always @(negedge clk) if (!rst) begin
        if (gnt != 0) begin
            if (gq.size() == 0) chk("gnt_unexpected", gnt, 0);
            else chk("gnt_order", gnt, gq.pop_front());
        end
        if (res_valid && res_ready) begin
            if (rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL res_unexpected: got id %0d product %0d with nothing expected", res_id, res_product);
            end else begin
                e = rq.pop_front();
                chk("res_id", res_id, e[9:8]);
                chk("res_product", res_product, e[7:0]);
            end
        end
    end

    task automatic wait_gnt(input string name, output int cy);
        cy = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt != 0) begin cy = cyc; return; end
        end
        checks++; errors++;
        $display("FAIL %s: no grant within 20 cycles, got %0h expected nonzero", name, gnt);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; req = 0; res_ready = 0;
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_gnt", gnt, 0);
            chk("rst_valid", res_valid, 0);
            chk("rst_product", res_product, 0);
            chk("rst_count", ops_count, 0);
            chk("rst_busy", busy, 0);
        end
        @(posedge clk); #1;
        rst = 0; req = 0;

        // single op
        @(posedge clk); #1;
        req = 4'b0001; a_in = 16'h0003; b_in = 16'h0005; res_ready = 1;
        gq.push_back(4'b0001); rq.push_back({2'd0, 8'd15});
        @(negedge clk); chk("t1_gnt", gnt, 4'b0001);
        @(posedge clk); #1; req = 0;
        @(negedge clk); chk("t1_busy_t1", busy, 1); chk("t1_valid_t1", res_valid, 0);
        @(negedge clk); chk("t1_valid_t2", res_valid, 1);
        @(negedge clk); chk("t1_busy_t3", busy, 0); chk("t1_count", ops_count, 1);

        // round robin
        do_reset();
        req = 4'b1111; a_in = 16'hffff; b_in = 16'hffff; res_ready = 1;
        foreach (gq[i]) ;
        gq.push_back(4'b0001); gq.push_back(4'b0010); gq.push_back(4'b0100);
        gq.push_back(4'b1000); gq.push_back(4'b0001);
        rq.push_back({2'd0, 8'd225}); rq.push_back({2'd1, 8'd225}); rq.push_back({2'd2, 8'd225});
        rq.push_back({2'd3, 8'd225}); rq.push_back({2'd0, 8'd225});
        for (int k = 0; k < 5; k++) begin
            wait_gnt("rr_wait", c);
            if (k > 0) chk("rr_spacing", c - prev, 3);
            prev = c;
        end
        @(posedge clk); #1; req = 0;
        repeat (3) @(negedge clk);

        // fairness between requesters 0 and 2
        do_reset();
        req = 4'b0101; a_in = 16'h0402; b_in = 16'h0503; res_ready = 1;
        for (int k = 0; k < 2; k++) begin
            gq.push_back(4'b0001); gq.push_back(4'b0100);
            rq.push_back({2'd0, 8'd6}); rq.push_back({2'd2, 8'd20});
        end
        for (int k = 0; k < 4; k++) wait_gnt("fair_wait", c);
        @(posedge clk); #1; req = 0;
        repeat (3) @(negedge clk);

        // backpressure, then reset while holding
        @(posedge clk); #1;
        req = 4'b0010; a_in = 16'h0070; b_in = 16'h0090; res_ready = 0;
        gq.push_back(4'b0010);
        wait_gnt("bp_wait", c);
        @(posedge clk); #1; req = 4'b0001;
        @(negedge clk); @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_product", res_product, 63);
            chk("bp_id", res_id, 1);
            chk("bp_valid", res_valid, 1);
            chk("bp_count", ops_count, 4);
            chk("bp_gnt", gnt, 0);
            if (k < 4) @(negedge clk);
        end
        @(posedge clk); #1; rst = 1; res_ready = 1;
        @(negedge clk); chk("rst_hold_gnt", gnt, 0);
        @(negedge clk);
        chk("rst_hold_valid", res_valid, 0);
        chk("rst_hold_count", ops_count, 0);
        chk("rst_hold_busy", busy, 0);
        @(posedge clk); #1; rst = 0; req = 4'b1111;
        gq.push_back(4'b0001); rq.push_back({2'd0, 8'd0});
        wait_gnt("ptr_wait", c);
        @(posedge clk); #1; req = 0;
        repeat (3) @(negedge clk);

        // exhaustive operand sweep through requester 1 with random stalls
        do_reset();
        for (int a = 0; a < 16; a++) for (int b = 0; b < 16; b++) begin
            @(posedge clk); #1;
            req = 4'b0010; a_in = 16'(a) << 4; b_in = 16'(b) << 4; res_ready = 1'($urandom_range(0, 1));
            gq.push_back(4'b0010); rq.push_back({2'd1, 8'(a * b)});
            wait_gnt("ex_wait", c);
            @(posedge clk); #1; req = 0;
            hs = 0;
            for (int i = 0; i < 50 && !hs; i++) begin
                res_ready = (i >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
                @(negedge clk);
                hs = res_valid && res_ready;
                if (!hs) begin @(posedge clk); #1; end
            end
            if (!hs) begin
                checks++; errors++;
                $display("FAIL ex_handshake: got no handshake expected one for a=%0d b=%0d", a, b);
            end
        end
        @(posedge clk); #1; res_ready = 0;
        @(negedge clk); chk("ex_count", ops_count, 256);
        chk("scoreboard_empty", rq.size() + gq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
